// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: issues word-aligned fetches, buffers returned
// words per entry, delivers the head to IF/ID, and drops responses made stale by a redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   pc_q   [DEPTH];
  logic [63:0]   pc_d   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic          accept_c, consume_c, fill_c;
  logic [CW:0]   credit_c, outstanding_c;

  // Stale requests still hold credit so the memory never sees more than DEPTH in flight.
  assign credit_c       = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = reset & ~redirect & (credit_c < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept_c       = imem_req_valid & imem_req_ready;

  assign inst_valid = filled_q[head_q];
  assign inst_out   = inst_q[head_q];
  assign inst_pc    = pc_q[head_q];
  assign consume_c  = filled_q[head_q] & ~stall & ~redirect;

  assign outstanding_c = {1'b0, drop_q} + {1'b0, pend_q};

  // Next-state: redirect flushes everything; otherwise allocate, fill and consume independently.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    filled_d   = filled_q;
    fill_c     = 1'b0;

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      fetch_pc_d = redirect_pc & ~64'd3;
      if (imem_resp_valid && (outstanding_c != '0)) begin
        drop_d = CW'(outstanding_c - (CW+1)'(1));
      end else begin
        drop_d = CW'(outstanding_c);
      end
    end else begin
      if (accept_c) begin
        pc_d[tail_q]     = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
        fetch_pc_d       = fetch_pc_q + 64'd4;
      end

      // Responses arrive in order: stale ones are discarded first, then the oldest pending entry fills.
      if (imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (pend_q != '0) begin
          inst_d[fill_q]   = imem_resp_data;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PW'(1);
          fill_c           = 1'b1;
        end
      end

      if (consume_c) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end

      if (accept_c && !consume_c) begin
        count_d = count_q + CW'(1);
      end else if (!accept_c && consume_c) begin
        count_d = count_q - CW'(1);
      end

      if (accept_c && !fill_c) begin
        pend_d = pend_q + CW'(1);
      end else if (!accept_c && fill_c) begin
        pend_d = pend_q - CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      filled_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      filled_q   <= filled_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue: an in-order memory model with variable
// latency plus a program-order model of fetch and delivery addresses.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect, stall;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc, last_due, lat_min, lat_max;
  int          checks, errors, delivered;
  logic [63:0] fetch_exp, deliver_exp;
  logic        s_req_valid, s_inst_valid;
  logic [63:0] s_req_addr, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs, advance the reference models.
  task automatic step(input bit rd, input logic [63:0] rpc, input bit st, input bit rdy,
                      input bit spur);
    int lat, due;
    @(negedge clk);
    redirect        = rd;
    redirect_pc     = rpc;
    stall           = st;
    imem_req_ready  = rdy;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else if (spur && mq.size() == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, fetch_exp);
    if (rd) check_eq("req_valid_on_redirect", 64'(imem_req_valid), 64'd0);
    if (inst_valid && !rd) begin
      check_eq("inst_pc", inst_pc, deliver_exp);
      check_eq("inst_out", 64'(inst_out), 64'(mem_word(deliver_exp)));
    end
    if (imem_req_valid && rdy) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: fetch_exp, due: due});
      check_eq("credit", 64'(mq.size() <= int'(DEPTH)), 64'd1);
      fetch_exp = fetch_exp + 64'd4;
    end
    if (inst_valid && !st && !rd) begin
      delivered++;
      deliver_exp = deliver_exp + 64'd4;
    end
    if (rd) begin
      fetch_exp   = rpc & ~64'd3;
      deliver_exp = rpc & ~64'd3;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset           = 1'b0;
    redirect        = 1'b0;
    stall           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    mq.delete();
    repeat (2) @(negedge clk);
    reset       = 1'b1;
    fetch_exp   = RESET_PC;
    deliver_exp = RESET_PC;
    last_due    = cyc;
  endtask

  initial begin
    int  d0;
    bit  seen;
    clk = 1'b0; reset = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    checks = 0; errors = 0; delivered = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1;
    fetch_exp = RESET_PC; deliver_exp = RESET_PC;

    // Streaming at 1-cycle latency, with an unsolicited response on the first cycle.
    do_reset();
    d0 = delivered;
    step(0, '0, 0, 1, 1);
    for (int i = 1; i < 20; i++) step(0, '0, 0, 1, 0);
    check_eq("stream_rate", 64'(delivered - d0), 64'd18);

    // Back-pressure: hold stall for 6 cycles, then release.
    begin
      logic [63:0] held_pc;
      step(0, '0, 1, 1, 0);
      held_pc = s_inst_pc;
      for (int i = 1; i < 6; i++) step(0, '0, 1, 1, 0);
      check_eq("bp_req_valid", 64'(s_req_valid), 64'd0);
      check_eq("bp_inst_valid", 64'(s_inst_valid), 64'd1);
      check_eq("bp_pc_held", s_inst_pc, held_pc);
    end
    d0 = delivered;
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1, 0);
    check_eq("bp_flow", 64'((delivered - d0) >= 8), 64'd1);

    // Redirect to 0x100 with several requests in flight at latency 3.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1, 0);
    step(1, 64'h100, 0, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, '0, 0, 1, 0);
      if (s_inst_valid) begin
        seen = 1'b1;
        check_eq("redirect_first_pc", s_inst_pc, 64'h100);
      end
    end
    if (!seen) check_eq("redirect_timeout", 64'd0, 64'd1);

    // Misaligned redirect target.
    step(1, 64'h10E, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    check_eq("misaligned_addr", s_req_addr, 64'h10C);
    for (int i = 0; i < 15; i++) step(0, '0, 0, 1, 0);

    // Redirect coinciding with a response and a would-be consume.
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) step(0, '0, 0, 1, 0);
    step(1, 64'h2000, 0, 1, 0);
    check_eq("sim_inst_valid", 64'(s_inst_valid), 64'd1);
    d0 = delivered;
    for (int i = 0; i < 15; i++) step(0, '0, 0, 1, 0);
    check_eq("sim_resume", 64'((delivered - d0) > 0), 64'd1);

    // Random latency, ready, stall and redirects, with a reset mid-run.
    lat_min = 1; lat_max = 5;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      bit          rd;
      if (i == 1500) do_reset();
      rd  = ($urandom % 100) < 3;
      rpc = (($urandom % 8) == 0) ? 64'hFFFF_FFFF_FFFF_FFF2 : {$urandom, $urandom};
      step(rd, rpc, ($urandom % 100) < 30, ($urandom % 100) < 70, ($urandom % 50) == 0);
    end
    check_eq("random_progress", 64'((delivered - d0) > 200), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries (power of two, at least 2).
REQ-002 Parameter: RESET_PC, default 64'd0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request is valid this cycle.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  64  fetch address, word-aligned.
REQ-008 imem_resp_valid  input  1  fetched word is returned this cycle.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 redirect  input  1  branch-taken/flush pulse from the EX/MEM branch control.
REQ-011 redirect_pc  input  64  new fetch address when redirect=1.
REQ-012 stall  input  1  decode/IF-ID hold (load-use stall).
REQ-013 inst_valid  output  1  inst_out and inst_pc are valid.
REQ-014 inst_out  output  32  instruction delivered to the IF/ID register.
REQ-015 inst_pc  output  64  address of inst_out.

Function
REQ-016 The memory SHALL return responses strictly in request order, at least 1 cycle after acceptance; fetch_queue SHALL NOT require a fixed latency.
REQ-017 The request handshake SHALL complete on a cycle with imem_req_valid=1 and imem_req_ready=1; imem_req_addr SHALL hold stable while valid=1 and ready=0, unless redirect=1.
REQ-018 Each accepted request SHALL allocate the tail entry, storing {pc, filled=0}; fetch_pc SHALL then advance by 4, with 64-bit wrap-around.
REQ-019 imem_req_valid SHALL be 1 only when allocated entries < DEPTH and redirect=0.
REQ-020 A kept response SHALL write imem_resp_data into the oldest allocated unfilled entry and set filled=1.
REQ-021 inst_valid SHALL equal the filled bit of the head entry; inst_out and inst_pc SHALL be driven from the head entry combinationally.
REQ-022 The head entry SHALL be consumed (head pointer +1, mod DEPTH) on a cycle with inst_valid=1, stall=0 and redirect=0.
REQ-023 While stall=1, the head entry SHALL remain unchanged and fetching SHALL continue until the queue is full.
REQ-024 Allocation, fill and consume SHALL all be allowed in the same cycle; occupancy SHALL change by +1, 0 or -1 as appropriate.
REQ-025 On redirect=1, the following SHALL happen in one cycle, taking priority over every other event:
- all entries cleared;
- fetch_pc set to {redirect_pc[63:2], 2'b00};
- drop_cnt set to (number of outstanding unfilled requests) minus (1 if a response arrives in the same cycle).
REQ-026 While drop_cnt > 0, each response SHALL be discarded and drop_cnt decremented; a discarded response SHALL never become visible on inst_out.
REQ-027 Fetching SHALL resume on the cycle after a redirect, without waiting for drop_cnt to reach 0.
REQ-028 Allocation SHALL count entries that are allocated and filled plus entries that are allocated and pending; dropped requests SHALL still occupy credit (total in flight ≤ DEPTH) until their responses return.
REQ-029 A response arriving when no request is outstanding SHALL be ignored.
REQ-030 inst_valid SHALL never be 1 for a queue entry allocated before the most recent redirect.

Reset
REQ-031 While reset=0, the block SHALL set:
- fetch_pc = RESET_PC;
- head, tail, occupancy, drop_cnt = 0;
- every filled bit = 0;
- imem_req_valid = 0 and inst_valid = 0.
REQ-032 These values SHALL apply asynchronously on assertion; the first request SHALL occur on the first clock edge after reset deasserts.
REQ-033 Assertion of reset while requests are outstanding SHALL discard their later responses; the memory SHALL be reset concurrently.

Verification
REQ-034 Streaming: ready=1, 1-cycle latency, stall=0 -> inst_pc sequence 0,4,8,12,… with one instruction per cycle after the 2-cycle startup.
REQ-035 Back-pressure: stall held for 6 cycles -> the queue fills to 4 entries, imem_req_valid=0, and inst_pc stays fixed; after release, instructions flow with none lost or duplicated.
REQ-036 Redirect with 3 in flight: redirect_pc=0x100 at cycle 10 -> the 3 stale responses are dropped, and the first inst_valid shows inst_pc=0x100.
REQ-037 Misaligned redirect: redirect_pc=0x10E -> imem_req_addr=0x10C.
REQ-038 Simultaneous redirect, response and consume in one cycle -> redirect wins, and no stale instruction appears afterward.
REQ-039 Random latency (1-5 cycles), random ready and stall -> a scoreboard shows every delivered {pc, inst} matches the memory model in program order.
